// File: rtl/t03_load_store_unit.sv
// t03_load_store_unit
// Data-memory stage. Each load or store becomes one word-addressed bus
// transaction. The unit selects byte lanes, replicates store data across the
// lanes and sign- or zero-extends load data. It keeps the pipeline frozen
// until the access completes, times out or is rejected.
module t03_load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  dataWidth,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    input  logic        busAck,
    input  logic [31:0] busRData,
    output logic [31:0] busAddr,
    output logic [31:0] busWData,
    output logic [3:0]  busSel,
    output logic        busRead,
    output logic        busWrite,
    output logic [31:0] loadData,
    output logic        freeze,
    output logic        misaligned,
    output logic        busErr
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Reject requests that no single bus access can serve.
    function automatic logic is_illegal(input logic rd, input logic wr,
                                        input logic [2:0] w, input logic [1:0] a);
        logic bad;
        case (w)
            W_B, W_BU: bad = 1'b0;
            W_H, W_HU: bad = a[0];
            W_W:       bad = (a != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

    // Compute the byte-lane enables for a given width and byte offset.
    function automatic logic [3:0] lane_sel(input logic [2:0] w, input logic [1:0] a);
        logic [3:0] sel;
        case (w)
            W_B, W_BU: sel = 4'b0001 << a;
            W_H, W_HU: sel = a[1] ? 4'b1100 : 4'b0011;
            W_W:       sel = 4'b1111;
            default:   sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Replicate right-aligned store data so that every enabled lane carries it.
    function automatic logic [31:0] align_wdata(input logic [2:0] w, input logic [31:0] sd);
        logic [31:0] wd;
        case (w)
            W_B, W_BU: wd = {4{sd[7:0]}};
            W_H, W_HU: wd = {2{sd[15:0]}};
            W_W:       wd = sd;
            default:   wd = 32'h0000_0000;
        endcase
        return wd;
    endfunction

    // Extract the addressed byte or halfword and extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [2:0] w, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            2'b11:   b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (w)
            W_B:     res = {{24{b[7]}}, b};
            W_BU:    res = {24'h00_0000, b};
            W_H:     res = {{16{h[15]}}, h};
            W_HU:    res = {16'h0000, h};
            W_W:     res = rd;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    state_t        state_r, state_s;
    logic [31:0]   bus_addr_r, bus_addr_s;
    logic [31:0]   bus_wdata_r, bus_wdata_s;
    logic [3:0]    bus_sel_r, bus_sel_s;
    logic          bus_read_r, bus_read_s;
    logic          bus_write_r, bus_write_s;
    logic [31:0]   load_data_r, load_data_s;
    logic          misaligned_r, misaligned_s;
    logic          bus_err_r, bus_err_s;
    logic [2:0]    width_r, width_s;
    logic [1:0]    lane_r, lane_s;
    logic          dir_wr_r, dir_wr_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          req_s;
    logic          illegal_s;

    assign req_s     = memRead | memWrite;
    assign illegal_s = is_illegal(memRead, memWrite, dataWidth, addr[1:0]);

    // Next-state and next-register logic for the IDLE/BUS/DONE sequencer.
    always_comb begin
        state_s      = state_r;
        bus_addr_s   = bus_addr_r;
        bus_wdata_s  = bus_wdata_r;
        bus_sel_s    = bus_sel_r;
        bus_read_s   = bus_read_r;
        bus_write_s  = bus_write_r;
        load_data_s  = load_data_r;
        misaligned_s = 1'b0;
        bus_err_s    = 1'b0;
        width_s      = width_r;
        lane_s       = lane_r;
        dir_wr_s     = dir_wr_r;
        cnt_s        = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (req_s) begin
                    if (illegal_s) begin
                        misaligned_s = 1'b1;
                        state_s      = S_DONE;
                    end else begin
                        bus_addr_s  = {addr[31:2], 2'b00};
                        bus_wdata_s = align_wdata(dataWidth, storeData);
                        bus_sel_s   = lane_sel(dataWidth, addr[1:0]);
                        width_s     = dataWidth;
                        lane_s      = addr[1:0];
                        dir_wr_s    = memWrite;
                        bus_read_s  = memRead;
                        bus_write_s = memWrite;
                        cnt_s       = '0;
                        state_s     = S_BUS;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BUS: begin
                if (busAck) begin
                    if (!dir_wr_r) begin
                        load_data_s = extend_load(width_r, lane_r, busRData);
                    end else begin
                        load_data_s = load_data_r;
                    end
                    bus_read_s  = 1'b0;
                    bus_write_s = 1'b0;
                    cnt_s       = '0;
                    state_s     = S_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    // The slave never answered: abort and flag the error.
                    load_data_s = 32'h0000_0000;
                    bus_err_s   = 1'b1;
                    bus_read_s  = 1'b0;
                    bus_write_s = 1'b0;
                    cnt_s       = '0;
                    state_s     = S_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_DONE: begin
                // The pipeline advances on this edge and any request is ignored.
                bus_read_s  = 1'b0;
                bus_write_s = 1'b0;
                state_s     = S_IDLE;
            end
            default: begin
                bus_read_s  = 1'b0;
                bus_write_s = 1'b0;
                cnt_s       = '0;
                state_s     = S_IDLE;
            end
        endcase
    end

    // State and output registers. An asynchronous reset drops the strobes at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= S_IDLE;
            bus_addr_r   <= 32'h0000_0000;
            bus_wdata_r  <= 32'h0000_0000;
            bus_sel_r    <= 4'b0000;
            bus_read_r   <= 1'b0;
            bus_write_r  <= 1'b0;
            load_data_r  <= 32'h0000_0000;
            misaligned_r <= 1'b0;
            bus_err_r    <= 1'b0;
            width_r      <= 3'b000;
            lane_r       <= 2'b00;
            dir_wr_r     <= 1'b0;
            cnt_r        <= '0;
        end else begin
            state_r      <= state_s;
            bus_addr_r   <= bus_addr_s;
            bus_wdata_r  <= bus_wdata_s;
            bus_sel_r    <= bus_sel_s;
            bus_read_r   <= bus_read_s;
            bus_write_r  <= bus_write_s;
            load_data_r  <= load_data_s;
            misaligned_r <= misaligned_s;
            bus_err_r    <= bus_err_s;
            width_r      <= width_s;
            lane_r       <= lane_s;
            dir_wr_r     <= dir_wr_s;
            cnt_r        <= cnt_s;
        end
    end

    // The stall request must reach the PC in the same cycle as the request.
    assign freeze     = ((state_r == S_IDLE) && req_s) || (state_r == S_BUS);
    assign busAddr    = bus_addr_r;
    assign busWData   = bus_wdata_r;
    assign busSel     = bus_sel_r;
    assign busRead    = bus_read_r;
    assign busWrite   = bus_write_r;
    assign loadData   = load_data_r;
    assign misaligned = misaligned_r;
    assign busErr     = bus_err_r;

endmodule

// File: tb/tb_t03_load_store_unit.sv
// Directed self-checking bench for t03_load_store_unit (TIMEOUT = 4).
module tb_t03_load_store_unit;

    logic        clk;
    logic        nrst;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  dataWidth;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        busAck;
    logic [31:0] busRData;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  busSel;
    logic        busRead;
    logic        busWrite;
    logic [31:0] loadData;
    logic        freeze;
    logic        misaligned;
    logic        busErr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Results measured by run_access.
    int          r_fcnt;
    int          r_scnt;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;
    logic [31:0] r_baddr;
    logic        r_to;

    t03_load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .nrst(nrst), .memRead(memRead), .memWrite(memWrite),
        .dataWidth(dataWidth), .addr(addr), .storeData(storeData),
        .busAck(busAck), .busRData(busRData), .busAddr(busAddr),
        .busWData(busWData), .busSel(busSel), .busRead(busRead),
        .busWrite(busWrite), .loadData(loadData), .freeze(freeze),
        .misaligned(misaligned), .busErr(busErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in the IDLE cycle and count freeze/strobe cycles until
    // freeze drops. The slave acks after 'waits' unacked BUS cycles (-1: never).
    // The task returns 2 time units after the edge that entered DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] w,
                              input logic [31:0] a, input logic [31:0] sd,
                              input int waits, input logic [31:0] rdata);
        r_fcnt = 0; r_scnt = 0; r_sel = 4'h0; r_wdata = 32'h0; r_baddr = 32'h0; r_to = 1'b1;
        memRead = rd; memWrite = wr; dataWidth = w; addr = a; storeData = sd;
        for (int i = 0; i < 40; i++) begin
            busAck = 1'b0;
            #1;
            if (!freeze) begin
                r_to = 1'b0;
                break;
            end
            r_fcnt++;
            if (busRead || busWrite) begin
                r_scnt++;
                r_sel = busSel; r_wdata = busWData; r_baddr = busAddr;
                if (waits >= 0 && r_scnt == waits + 1) begin
                    busAck = 1'b1;
                    busRData = rdata;
                end
            end
            next_cycle();
            memRead = 1'b0; memWrite = 1'b0;
        end
        busAck = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if ({busRead, busWrite, freeze, misaligned, busErr} !== 5'b0) $display("FAIL reset_strobes: got %b expected 00000", {busRead, busWrite, freeze, misaligned, busErr}); else pass_cnt++;
        total_cnt++; if (loadData !== 32'h0) $display("FAIL reset_loadData: got %h expected 00000000", loadData); else pass_cnt++;
        total_cnt++; if ({busAddr, busWData, busSel} !== 68'h0) $display("FAIL reset_bus: got %h %h %b expected zeros", busAddr, busWData, busSel); else pass_cnt++;
        next_cycle();
        nrst = 1'b1;
        next_cycle();
        total_cnt++; if (freeze !== 1'b0) $display("FAIL reset_idle_freeze: got %b expected 0", freeze); else pass_cnt++;
    endtask

    task automatic test_lw();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
        total_cnt++; if (r_to !== 1'b0) $display("FAIL lw_timeout: got %b expected 0", r_to); else pass_cnt++;
        total_cnt++; if (r_baddr !== 32'h0000_0100) $display("FAIL lw_busAddr: got %h expected 00000100", r_baddr); else pass_cnt++;
        total_cnt++; if (r_sel !== 4'b1111) $display("FAIL lw_busSel: got %b expected 1111", r_sel); else pass_cnt++;
        total_cnt++; if (loadData !== 32'hDEAD_BEEF) $display("FAIL lw_loadData: got %h expected deadbeef", loadData); else pass_cnt++;
        total_cnt++; if (r_fcnt !== 2) $display("FAIL lw_freeze_cycles: got %0d expected 2", r_fcnt); else pass_cnt++;
        total_cnt++; if (r_scnt !== 1) $display("FAIL lw_read_cycles: got %0d expected 1", r_scnt); else pass_cnt++;
        total_cnt++; if ({busRead, misaligned, busErr} !== 3'b000) $display("FAIL lw_done_flags: got %b expected 000", {busRead, misaligned, busErr}); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_byte_loads();
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 0, 32'h8012_3456);
        total_cnt++; if (r_sel !== 4'b1000) $display("FAIL lb_busSel: got %b expected 1000", r_sel); else pass_cnt++;
        total_cnt++; if (r_baddr !== 32'h0000_0200) $display("FAIL lb_busAddr: got %h expected 00000200", r_baddr); else pass_cnt++;
        total_cnt++; if (loadData !== 32'hFFFF_FF80) $display("FAIL lb_loadData: got %h expected ffffff80", loadData); else pass_cnt++;
        next_cycle();
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 0, 32'h8012_3456);
        total_cnt++; if (loadData !== 32'h0000_0080) $display("FAIL lbu_loadData: got %h expected 00000080", loadData); else pass_cnt++;
        next_cycle();
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_0201, 32'h0, 0, 32'h8012_C456);
        total_cnt++; if (r_sel !== 4'b0010) $display("FAIL lbu1_busSel: got %b expected 0010", r_sel); else pass_cnt++;
        total_cnt++; if (loadData !== 32'h0000_00C4) $display("FAIL lbu1_loadData: got %h expected 000000c4", loadData); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_half_loads();
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0300, 32'h0, 0, 32'h1234_F00D);
        total_cnt++; if (r_sel !== 4'b0011) $display("FAIL lh_busSel: got %b expected 0011", r_sel); else pass_cnt++;
        total_cnt++; if (loadData !== 32'hFFFF_F00D) $display("FAIL lh_loadData: got %h expected fffff00d", loadData); else pass_cnt++;
        next_cycle();
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0, 0, 32'h8001_7777);
        total_cnt++; if (r_sel !== 4'b1100) $display("FAIL lhu_busSel: got %b expected 1100", r_sel); else pass_cnt++;
        total_cnt++; if (loadData !== 32'h0000_8001) $display("FAIL lhu_loadData: got %h expected 00008001", loadData); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_stores();
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 3, 32'h0);
        total_cnt++; if (r_sel !== 4'b1100) $display("FAIL sh_busSel: got %b expected 1100", r_sel); else pass_cnt++;
        total_cnt++; if (r_wdata !== 32'hABCD_ABCD) $display("FAIL sh_busWData: got %h expected abcdabcd", r_wdata); else pass_cnt++;
        total_cnt++; if (r_baddr !== 32'h0000_0040) $display("FAIL sh_busAddr: got %h expected 00000040", r_baddr); else pass_cnt++;
        total_cnt++; if (r_scnt !== 4) $display("FAIL sh_write_cycles: got %0d expected 4", r_scnt); else pass_cnt++;
        total_cnt++; if (r_fcnt !== 5) $display("FAIL sh_freeze_cycles: got %0d expected 5", r_fcnt); else pass_cnt++;
        total_cnt++; if (loadData !== 32'h0000_8001) $display("FAIL sh_loadData_kept: got %h expected 00008001", loadData); else pass_cnt++;
        total_cnt++; if (busWrite !== 1'b0) $display("FAIL sh_done_strobe: got %b expected 0", busWrite); else pass_cnt++;
        next_cycle();
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'hFFFF_FFA5, 0, 32'h0);
        total_cnt++; if (r_sel !== 4'b0010) $display("FAIL sb_busSel: got %b expected 0010", r_sel); else pass_cnt++;
        total_cnt++; if (r_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_busWData: got %h expected a5a5a5a5", r_wdata); else pass_cnt++;
        next_cycle();
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0080, 32'h1122_3344, 1, 32'h0);
        total_cnt++; if (r_sel !== 4'b1111) $display("FAIL sw_busSel: got %b expected 1111", r_sel); else pass_cnt++;
        total_cnt++; if (r_wdata !== 32'h1122_3344) $display("FAIL sw_busWData: got %h expected 11223344", r_wdata); else pass_cnt++;
        total_cnt++; if (r_fcnt !== 3) $display("FAIL sw_freeze_cycles: got %0d expected 3", r_fcnt); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_misaligned();
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0010, 32'h0, 0, 32'h0000_005A);
        total_cnt++; if (loadData !== 32'h0000_005A) $display("FAIL mis_setup_loadData: got %h expected 0000005a", loadData); else pass_cnt++;
        next_cycle();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'hFFFF_FFFF);
        total_cnt++; if (r_scnt !== 0) $display("FAIL mis_lw_strobes: got %0d expected 0", r_scnt); else pass_cnt++;
        total_cnt++; if (r_fcnt !== 1) $display("FAIL mis_lw_freeze: got %0d expected 1", r_fcnt); else pass_cnt++;
        total_cnt++; if (misaligned !== 1'b1) $display("FAIL mis_lw_pulse: got %b expected 1", misaligned); else pass_cnt++;
        total_cnt++; if (loadData !== 32'h0000_005A) $display("FAIL mis_lw_loadData: got %h expected 0000005a", loadData); else pass_cnt++;
        next_cycle();
        total_cnt++; if (misaligned !== 1'b0) $display("FAIL mis_pulse_width: got %b expected 0", misaligned); else pass_cnt++;
        run_access(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hFFFF_FFFF);
        total_cnt++; if ({r_scnt, misaligned} !== {32'd0, 1'b1}) $display("FAIL mis_both_strobes: got %0d/%b expected 0/1", r_scnt, misaligned); else pass_cnt++;
        next_cycle();
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0, 0, 32'hFFFF_FFFF);
        total_cnt++; if ({r_scnt, misaligned} !== {32'd0, 1'b1}) $display("FAIL mis_half_odd: got %0d/%b expected 0/1", r_scnt, misaligned); else pass_cnt++;
        next_cycle();
        run_access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'hFFFF_FFFF);
        total_cnt++; if ({r_scnt, misaligned} !== {32'd0, 1'b1}) $display("FAIL mis_bad_width: got %0d/%b expected 0/1", r_scnt, misaligned); else pass_cnt++;
        total_cnt++; if (loadData !== 32'h0000_005A) $display("FAIL mis_final_loadData: got %h expected 0000005a", loadData); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, -1, 32'h0);
        total_cnt++; if (r_to !== 1'b0) $display("FAIL to_bound: got %b expected 0", r_to); else pass_cnt++;
        total_cnt++; if (r_scnt !== 4) $display("FAIL to_read_cycles: got %0d expected 4", r_scnt); else pass_cnt++;
        total_cnt++; if (r_fcnt !== 5) $display("FAIL to_freeze_cycles: got %0d expected 5", r_fcnt); else pass_cnt++;
        total_cnt++; if (busErr !== 1'b1) $display("FAIL to_busErr: got %b expected 1", busErr); else pass_cnt++;
        total_cnt++; if (loadData !== 32'h0) $display("FAIL to_loadData: got %h expected 00000000", loadData); else pass_cnt++;
        next_cycle();
        total_cnt++; if (busErr !== 1'b0) $display("FAIL to_pulse_width: got %b expected 0", busErr); else pass_cnt++;
    endtask

    task automatic test_reset_mid_bus();
        memRead = 1'b1; dataWidth = 3'b010; addr = 32'h0000_0010;
        next_cycle();
        memRead = 1'b0;
        #1;
        total_cnt++; if (busRead !== 1'b1) $display("FAIL rst_bus_entered: got %b expected 1", busRead); else pass_cnt++;
        nrst = 1'b0;
        #1;
        total_cnt++; if ({busRead, freeze} !== 2'b00) $display("FAIL rst_mid_bus: got %b expected 00", {busRead, freeze}); else pass_cnt++;
        next_cycle();
        nrst = 1'b1;
        next_cycle();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, 32'hCAFE_F00D);
        total_cnt++; if (loadData !== 32'hCAFE_F00D) $display("FAIL rst_after_lw: got %h expected cafef00d", loadData); else pass_cnt++;
        total_cnt++; if (r_fcnt !== 2) $display("FAIL rst_after_freeze: got %0d expected 2", r_fcnt); else pass_cnt++;
        next_cycle();
    endtask

    initial begin
        nrst = 1'b0; memRead = 1'b0; memWrite = 1'b0; dataWidth = 3'b000;
        addr = 32'h0; storeData = 32'h0; busAck = 1'b0; busRData = 32'h0;
        next_cycle();
        test_reset();
        test_lw();
        test_byte_loads();
        test_half_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid_bus();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
